// File: rtl/ac_pkg.sv
// Shared widths, root-state constant and traversal FSM encoding for the
// Aho-Corasick match engine and its goto table.
package ac_pkg;
    localparam int STATE_W = 8;
    localparam int CHAR_W  = 8;
    localparam int GADDR_W = STATE_W + CHAR_W;
    localparam int FADDR_W = 12;
    localparam logic [STATE_W-1:0] ROOT_STATE = '0;

    typedef enum logic [2:0] {
        IDLE,
        G_RD,
        G_EV,
        F_RD,
        F_EV
    } ac_fsm_t;

    function automatic logic [GADDR_W-1:0] goto_addr(
        input logic [STATE_W-1:0] state,
        input logic [CHAR_W-1:0]  ch
    );
        return {state, ch};
    endfunction
endpackage

// File: rtl/ac_goto_ram.sv
// Synchronous-read goto/output table: word = {accept, hit, next_state}.
// A write port lets the table generator (or a loader) fill it after power-up.
module ac_goto_ram
    import ac_pkg::*;
#(
    parameter int ADDR_W = GADDR_W,
    parameter int DATA_W = STATE_W + 2
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ac_match_engine.sv
// Aho-Corasick traversal controller: one byte per handshake, goto lookup,
// failure-link hops on a miss, registered match pulse and sticky error.
module ac_match_engine
    import ac_pkg::*;
#(
    parameter int MAX_FAIL_DEPTH = 16,
    parameter int POS_W          = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CHAR_W-1:0]    CHAR_IN,
    input  logic                 CHAR_VALID,
    output logic                 CHAR_READY,
    output logic [GADDR_W-1:0]   ADDR_G,
    input  logic [STATE_W-1:0]   GOTO_NEXT,
    input  logic                 GOTO_HIT,
    input  logic                 GOTO_ACCEPT,
    output logic [FADDR_W-1:0]   ADDR_F,
    input  logic [STATE_W-1:0]   CURRENT_STATE_F,
    input  logic [STATE_W-1:0]   FAILURE_STATE,
    output logic                 MATCH_VALID,
    output logic [STATE_W-1:0]   MATCH_STATE,
    output logic [POS_W-1:0]     MATCH_POS,
    output logic                 ERR
);
    localparam int DEPTH_W = $clog2(MAX_FAIL_DEPTH) + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_FAIL_DEPTH);

    ac_fsm_t              r_fsm;
    logic [STATE_W-1:0]   r_state;
    logic [CHAR_W-1:0]    r_char;
    logic [POS_W-1:0]     r_pos;
    logic [DEPTH_W-1:0]   r_depth;
    logic [GADDR_W-1:0]   r_addr_g;
    logic [STATE_W-1:0]   r_addr_f;
    logic                 r_match_valid;
    logic [STATE_W-1:0]   r_match_state;
    logic [POS_W-1:0]     r_match_pos;
    logic                 r_err;

    logic [DEPTH_W-1:0]   w_depth_inc;
    logic                 w_tag_bad;

    assign w_depth_inc = r_depth + 1'b1;
    assign w_tag_bad   = (CURRENT_STATE_F != r_state);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fsm         <= IDLE;
            r_state       <= ROOT_STATE;
            r_char        <= '0;
            r_pos         <= '0;
            r_depth       <= '0;
            r_addr_g      <= '0;
            r_addr_f      <= '0;
            r_match_valid <= 1'b0;
            r_match_state <= '0;
            r_match_pos   <= '0;
            r_err         <= 1'b0;
        end else begin
            r_match_valid <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (CHAR_VALID) begin
                        r_char   <= CHAR_IN;
                        r_addr_g <= goto_addr(r_state, CHAR_IN);
                        r_depth  <= '0;
                        r_fsm    <= G_RD;
                    end
                end
                G_RD: r_fsm <= G_EV;
                G_EV: begin
                    if (GOTO_HIT) begin
                        r_state <= GOTO_NEXT;
                        r_depth <= '0;
                        r_pos   <= r_pos + 1'b1;
                        if (GOTO_ACCEPT) begin
                            r_match_valid <= 1'b1;
                            r_match_state <= GOTO_NEXT;
                            r_match_pos   <= r_pos;
                        end
                        r_fsm <= IDLE;
                    end else if (r_state == ROOT_STATE) begin
                        // Root has an implicit self-loop on every unmatched byte.
                        r_pos <= r_pos + 1'b1;
                        r_fsm <= IDLE;
                    end else begin
                        r_addr_f <= r_state;
                        r_fsm    <= F_RD;
                    end
                end
                F_RD: r_fsm <= F_EV;
                F_EV: begin
                    // A corrupt row or a runaway failure chain drops the byte
                    // and restarts matching from the root.
                    if (w_tag_bad || (w_depth_inc == DEPTH_LIMIT)) begin
                        r_err   <= 1'b1;
                        r_state <= ROOT_STATE;
                        r_pos   <= r_pos + 1'b1;
                        r_fsm   <= IDLE;
                    end else begin
                        r_state  <= FAILURE_STATE;
                        r_depth  <= w_depth_inc;
                        r_addr_g <= goto_addr(FAILURE_STATE, r_char);
                        r_fsm    <= G_RD;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign CHAR_READY  = (r_fsm == IDLE);
    assign ADDR_G      = r_addr_g;
    assign ADDR_F      = {4'b0000, r_addr_f};
    assign MATCH_VALID = r_match_valid;
    assign MATCH_STATE = r_match_state;
    assign MATCH_POS   = r_match_pos;
    assign ERR         = r_err;
endmodule

// File: tb/tb_ac_match_engine.sv
// Directed bench for ac_match_engine over the {he, she, his, hers} automaton
// plus a corrupted row and a cyclic failure table.
module tb_ac_match_engine;
    import ac_pkg::*;

    localparam int POS_W = 16;

    logic                CLK = 1'b0;
    logic                RST;
    logic [7:0]          CHAR_IN;
    logic                CHAR_VALID;
    logic                CHAR_READY;
    logic [15:0]         ADDR_G;
    logic [7:0]          GOTO_NEXT;
    logic                GOTO_HIT;
    logic                GOTO_ACCEPT;
    logic [11:0]         ADDR_F;
    logic [7:0]          CURRENT_STATE_F;
    logic [7:0]          FAILURE_STATE;
    logic                MATCH_VALID;
    logic [7:0]          MATCH_STATE;
    logic [POS_W-1:0]    MATCH_POS;
    logic                ERR;

    logic                g_we;
    logic [15:0]         g_waddr;
    logic [9:0]          g_wdata;
    logic [9:0]          g_rdata;

    logic [7:0]          ftag  [256];
    logic [7:0]          ffail [256];

    int                  n_checks = 0;
    int                  n_fail   = 0;
    int                  addr_f_nz = 0;
    int                  lat_q[$];
    logic [31:0]         match_q[$];
    logic [7:0]          xfer_q[$];

    always #5 CLK = ~CLK;

    ac_match_engine #(.MAX_FAIL_DEPTH(4), .POS_W(POS_W)) dut (
        .CLK(CLK), .RST(RST), .CHAR_IN(CHAR_IN), .CHAR_VALID(CHAR_VALID),
        .CHAR_READY(CHAR_READY), .ADDR_G(ADDR_G), .GOTO_NEXT(GOTO_NEXT),
        .GOTO_HIT(GOTO_HIT), .GOTO_ACCEPT(GOTO_ACCEPT), .ADDR_F(ADDR_F),
        .CURRENT_STATE_F(CURRENT_STATE_F), .FAILURE_STATE(FAILURE_STATE),
        .MATCH_VALID(MATCH_VALID), .MATCH_STATE(MATCH_STATE),
        .MATCH_POS(MATCH_POS), .ERR(ERR)
    );

    ac_goto_ram u_goto (
        .i_clk(CLK), .i_we(g_we), .i_waddr(g_waddr), .i_wdata(g_wdata),
        .i_raddr(ADDR_G), .o_rdata(g_rdata)
    );
    assign {GOTO_ACCEPT, GOTO_HIT, GOTO_NEXT} = g_rdata;

    // Failure table stand-in with a registered read, like failure_ram.
    always @(posedge CLK) begin
        CURRENT_STATE_F <= ftag[ADDR_F[7:0]];
        FAILURE_STATE   <= ffail[ADDR_F[7:0]];
    end

    always @(negedge CLK) begin
        if (MATCH_VALID) match_q.push_back({7'd0, CHAR_READY, MATCH_STATE, MATCH_POS});
        if (ADDR_F != 12'd0) addr_f_nz++;
    end

    // Inputs only change at negedges, so pre-edge values are stable here.
    always @(posedge CLK) begin
        if (!RST && CHAR_VALID && CHAR_READY) xfer_q.push_back(CHAR_IN);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int st, input int pos);
        logic [7:0]  s8;
        logic [15:0] p16;
        s8  = st[7:0];
        p16 = pos[15:0];
        return {7'd0, 1'b1, s8, p16};
    endfunction

    task automatic gw(input int st, input logic [7:0] c, input logic [9:0] d);
        g_we    = 1'b1;
        g_waddr = {st[7:0], c};
        g_wdata = d;
        @(posedge CLK);
        #1 g_we = 1'b0;
    endtask

    task automatic clear_tables();
        string cs;
        cs = "aehirsuxyz";
        for (int st = 0; st < 16; st++)
            for (int i = 0; i < cs.len(); i++) gw(st, cs[i], 10'd0);
        for (int i = 0; i < 256; i++) begin
            ftag[i]  = i[7:0];
            ffail[i] = 8'd0;
        end
    endtask

    task automatic load_patterns();
        clear_tables();
        gw(0, "h", {2'b01, 8'd1});
        gw(0, "s", {2'b01, 8'd3});
        gw(1, "e", {2'b11, 8'd2});
        gw(1, "i", {2'b01, 8'd6});
        gw(2, "r", {2'b01, 8'd8});
        gw(3, "h", {2'b01, 8'd4});
        gw(4, "e", {2'b11, 8'd5});
        gw(6, "s", {2'b11, 8'd7});
        gw(8, "s", {2'b11, 8'd9});
        ffail[4] = 8'd1;
        ffail[5] = 8'd2;
        ffail[7] = 8'd3;
        ffail[9] = 8'd3;
    endtask

    task automatic load_cycle();
        clear_tables();
        gw(0, "a", {2'b01, 8'd1});
        ffail[1] = 8'd2;
        ffail[2] = 8'd1;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        CHAR_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
    endtask

    // Called at a negedge; returns at the negedge where CHAR_READY is back.
    task automatic send(input logic [7:0] c, output int lat);
        int w;
        CHAR_IN    = c;
        CHAR_VALID = 1'b1;
        w = 0;
        while (!CHAR_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (!CHAR_READY) begin
            check_eq("ready_timeout", {31'd0, CHAR_READY}, 32'd1);
            lat = -1;
            return;
        end
        @(posedge CLK);
        lat = 1;
        @(negedge CLK);
        while (!CHAR_READY && lat < 50) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
    endtask

    task automatic stream(input string s);
        int lat;
        lat_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], lat);
            lat_q.push_back(lat);
        end
        CHAR_VALID = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int exp_lat[$];
        RST        = 1'b1;
        CHAR_VALID = 1'b0;
        CHAR_IN    = 8'd0;
        g_we       = 1'b0;
        g_waddr    = '0;
        g_wdata    = '0;
        load_patterns();
        do_reset();

        check_eq("rst_ready", {31'd0, CHAR_READY}, 32'd1);
        check_eq("rst_addr_g", {16'd0, ADDR_G}, 32'd0);
        check_eq("rst_addr_f", {20'd0, ADDR_F}, 32'd0);
        check_eq("rst_match_valid", {31'd0, MATCH_VALID}, 32'd0);
        check_eq("rst_match_state", {24'd0, MATCH_STATE}, 32'd0);
        check_eq("rst_match_pos", {16'd0, MATCH_POS}, 32'd0);
        check_eq("rst_err", {31'd0, ERR}, 32'd0);

        // "ushers": she at pos 3, hers at pos 5, 'r' takes one failure hop.
        match_q.delete();
        stream("ushers");
        exp_lat = '{3, 3, 3, 3, 7, 3};
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("ushers_lat%0d", i), lat_q[i], exp_lat[i]);
        check_eq("ushers_nmatch", match_q.size(), 2);
        if (match_q.size() == 2) begin
            check_eq("ushers_m0", match_q[0], mk(5, 3));
            check_eq("ushers_m1", match_q[1], mk(9, 5));
        end
        check_eq("ushers_pos", 32'(dut.r_pos), 6);
        check_eq("ushers_state", 32'(dut.r_state), 9);

        // "xyz": root self-loop only.
        do_reset();
        match_q.delete();
        addr_f_nz = 0;
        stream("xyz");
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("xyz_lat%0d", i), lat_q[i], 3);
        check_eq("xyz_nmatch", match_q.size(), 0);
        check_eq("xyz_state", 32'(dut.r_state), 0);
        check_eq("xyz_pos", 32'(dut.r_pos), 3);
        check_eq("xyz_addr_f_activity", addr_f_nz, 0);

        // Corrupt tag on row 5, stream "sher".
        do_reset();
        match_q.delete();
        ftag[5] = 8'h07;
        stream("sher");
        ftag[5] = 8'h05;
        check_eq("tag_lat_r", lat_q[3], 5);
        check_eq("tag_err", {31'd0, ERR}, 32'd1);
        check_eq("tag_state", 32'(dut.r_state), 0);
        check_eq("tag_pos", 32'(dut.r_pos), 4);
        check_eq("tag_ready", {31'd0, CHAR_READY}, 32'd1);
        check_eq("tag_nmatch", match_q.size(), 1);
        if (match_q.size() == 1) check_eq("tag_m0", match_q[0], mk(5, 2));

        // Reset while in F_RD with a byte also offered.
        stream("she");
        check_eq("frd_err_sticky", {31'd0, ERR}, 32'd1);
        CHAR_IN    = "r";
        CHAR_VALID = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("frd_reached", 32'(dut.r_fsm), 32'(F_RD));
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST        = 1'b0;
        CHAR_VALID = 1'b0;
        @(negedge CLK);
        check_eq("frd_rst_ready", {31'd0, CHAR_READY}, 32'd1);
        check_eq("frd_rst_state", 32'(dut.r_state), 0);
        check_eq("frd_rst_pos", 32'(dut.r_pos), 0);
        check_eq("frd_rst_err", {31'd0, ERR}, 32'd0);
        check_eq("frd_rst_match_valid", {31'd0, MATCH_VALID}, 32'd0);
        check_eq("frd_rst_match_state", {24'd0, MATCH_STATE}, 32'd0);
        check_eq("frd_rst_addr_f", {20'd0, ADDR_F}, 32'd0);

        // CHAR_VALID held high across "hers": one byte per 3 cycles, none lost.
        match_q.delete();
        xfer_q.delete();
        stream("hers");
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("hold_lat%0d", i), lat_q[i], 3);
        check_eq("hold_nxfer", xfer_q.size(), 4);
        if (xfer_q.size() == 4) begin
            check_eq("hold_x0", {24'd0, xfer_q[0]}, 32'h68);
            check_eq("hold_x1", {24'd0, xfer_q[1]}, 32'h65);
            check_eq("hold_x2", {24'd0, xfer_q[2]}, 32'h72);
            check_eq("hold_x3", {24'd0, xfer_q[3]}, 32'h73);
        end
        check_eq("hold_nmatch", match_q.size(), 2);
        if (match_q.size() == 2) begin
            check_eq("hold_m0", match_q[0], mk(2, 1));
            check_eq("hold_m1", match_q[1], mk(9, 3));
        end

        // Failure cycle 1->2->1 with MAX_FAIL_DEPTH = 4.
        load_cycle();
        do_reset();
        match_q.delete();
        stream("az");
        check_eq("cyc_lat_a", lat_q[0], 3);
        check_eq("cyc_lat_z", lat_q[1], 17);
        check_eq("cyc_err", {31'd0, ERR}, 32'd1);
        check_eq("cyc_state", 32'(dut.r_state), 0);
        check_eq("cyc_pos", 32'(dut.r_pos), 2);
        check_eq("cyc_ready", {31'd0, CHAR_READY}, 32'd1);
        check_eq("cyc_nmatch", match_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
